gcd_host_seq: RTL and testbench
===============================

// Module: gcd_host_seq
// PURPOSE
//  Host-side initiator for the gcd engine's start/done interface. Accepts operand pairs on a
//  valid/ready request port and drives gcd_a/gcd_b/gcd_start. Holds the operands stable until
//  done, then returns the result on a valid/ready response port.
//  Enforces the engine's input contract: one start per job, nonzero operands, stable inputs.
// PARAMETERS
//  WIDTH           32    operand/result width; must match engine
//  TIMEOUT_CYCLES  4096  max WAIT cycles before abort (used only with GCD_TIMEOUT_EN)
// PORTS
//  clk          in   1      clock; all logic on posedge
//  reset        in   1      synchronous, active-high reset
//  req_valid    in   1      request operands valid
//  req_ready    out  1      request accepted when req_valid & req_ready
//  req_a        in   WIDTH  operand a
//  req_b        in   WIDTH  operand b
//  gcd_a        out  WIDTH  to engine a_in; registered
//  gcd_b        out  WIDTH  to engine b_in; registered
//  gcd_start    out  1      to engine start; single-cycle pulse
//  gcd_done     in   1      from engine done; one-cycle pulse
//  gcd_result   in   WIDTH  from engine result; sampled when gcd_done=1
//  rsp_valid    out  1      response valid; held until rsp_ready
//  rsp_ready    in   1      response consumed when rsp_valid & rsp_ready
//  rsp_result   out  WIDTH  gcd value
//  rsp_error    out  1      1 = no valid result (both operands zero, or timeout)
//  busy         out  1      1 whenever state != IDLE
// BEHAVIOUR
//  Reset (sync, reset=1 at posedge):
//   - state=IDLE; gcd_a, gcd_b, gcd_start, rsp_valid, rsp_result, rsp_error all 0.
//   - req_ready=1 in the first cycle after reset deasserts.
//   - Reset in any state, mid-job included, aborts the job; no response is produced.
//  FSM states: IDLE, START, WAIT, RESP.
//  IDLE:
//   - req_ready=1; this is the only state with req_ready high.
//   - On accept with req_a!=0 and req_b!=0: latch gcd_a=req_a, gcd_b=req_b; go to START.
//   - On accept with exactly one operand zero: rsp_result=the nonzero operand, rsp_error=0;
//     go to RESP. Engine is not started.
//   - On accept with both operands zero: rsp_result=0, rsp_error=1; go to RESP.
//   - gcd_done seen in IDLE is ignored.
//  START:
//   - gcd_start=1 for exactly this one cycle; next state is WAIT.
//   - gcd_done seen in START is ignored.
//  WAIT:
//   - gcd_start=0.
//   - On gcd_done=1: rsp_result<=gcd_result, rsp_error<=0; go to RESP.
//  RESP:
//   - rsp_valid=1; rsp_result and rsp_error held stable.
//   - On rsp_ready=1: rsp_valid drops next cycle; go to IDLE.
//   - gcd_done seen in RESP is ignored.
//  Operand hold rule:
//   - gcd_a/gcd_b change only on an accepted request.
//   - They are stable from START through RESP, so engine inputs never change mid-job.
//  Latency (engine path):
//   - Accept at cycle N; gcd_start at N+1.
//   - gcd_done at cycle D; rsp_valid at D+1.
//  Latency (bypass path): accept at N; rsp_valid at N+1.
//  Throughput: one job in flight; next accept no earlier than 1 cycle after rsp handshake.
//  busy=1 whenever state != IDLE.
// CONFIGURATION
//  GCD_TIMEOUT_EN defined:
//   - Counter cleared on entry to WAIT, increments each WAIT cycle.
//   - If TIMEOUT_CYCLES WAIT cycles pass with no gcd_done: rsp_result=0, rsp_error=1;
//     go to RESP.
//   - gcd_done in the same cycle as expiry wins: normal result, error=0.
//   - A late gcd_done after abort is ignored (not in WAIT).
//  GCD_TIMEOUT_EN undefined:
//   - No counter; WAIT holds indefinitely; rsp_error is set only for both-zero requests.
// TESTING
//  1. req (48,18), engine model returns 6 after 5 cycles
//     -> one gcd_start pulse at N+1; gcd_a=48, gcd_b=18 stable until done;
//        rsp_valid with result=6, error=0.
//  2. req (0,35) -> no gcd_start; rsp_result=35, error=0 at N+1.
//     req (0,0) -> rsp_result=0, error=1.
//  3. req (21,14), rsp_ready held low 10 cycles after rsp_valid
//     -> rsp_valid=1 and result=7 held throughout; req_ready=0; no extra start pulse.
//  4. reset pulsed in WAIT for req (100,75)
//     -> next cycle all outputs 0, busy=0; req_ready=1 after release;
//        later gcd_done produces no response.
//  5. gcd_done pulsed while IDLE, and again during START
//     -> no rsp_valid; FSM unaffected; a subsequent req (9,6) returns 3.
//  6. GCD_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never asserts done
//     -> rsp_valid with error=1, result=0 after 16 WAIT cycles.
//     Macro undefined -> busy=1 still at 1000 cycles.

Source files
------------

// File: rtl/gcd_host_seq.sv
// -----------------------------------------------------------------------------
// gcd_host_seq
//
// Host-side initiator for a gcd engine with a start/done handshake.
// Operand pairs arrive on a valid/ready request port. Pairs with both operands
// nonzero are sent to the engine: the operands are latched onto gcd_a/gcd_b,
// gcd_start pulses for one cycle, and the result is captured on gcd_done.
// Pairs containing a zero bypass the engine. If exactly one operand is zero,
// the answer is the other operand. If both are zero, the response is flagged
// as an error. Every answer is returned on a valid/ready response port.
//
// The engine's input contract is enforced here:
// - one start per job;
// - operands are always nonzero;
// - gcd_a/gcd_b do not change from START through RESP.
//
// Only one job is in flight at a time.
//
// Parameters
//   WIDTH           operand/result width; must match the engine
//   TIMEOUT_CYCLES  WAIT cycles allowed before a job is aborted
//                   (only used when GCD_TIMEOUT_EN is defined)
//
// Configuration macro
//   GCD_TIMEOUT_EN  defined   : a job that sees no gcd_done within
//                               TIMEOUT_CYCLES WAIT cycles ends with
//                               rsp_error=1 and rsp_result=0
//                   undefined : WAIT holds until gcd_done arrives
//
// Ports
//   clk         in   1      clock, all logic on posedge
//   reset       in   1      synchronous active-high reset; aborts any job
//   req_valid   in   1      request operands valid
//   req_ready   out  1      high only in IDLE
//   req_a       in   WIDTH  operand a
//   req_b       in   WIDTH  operand b
//   gcd_a       out  WIDTH  engine operand a, registered
//   gcd_b       out  WIDTH  engine operand b, registered
//   gcd_start   out  1      engine start, single-cycle pulse
//   gcd_done    in   1      engine done, single-cycle pulse
//   gcd_result  in   WIDTH  engine result, sampled with gcd_done
//   rsp_valid   out  1      response valid, held until rsp_ready
//   rsp_ready   in   1      response consumer ready
//   rsp_result  out  WIDTH  gcd value
//   rsp_error   out  1      no valid result (both operands zero, or timeout)
//   busy        out  1      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module gcd_host_seq #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] gcd_a,
   output logic [WIDTH-1:0] gcd_b,
   output logic             gcd_start,
   input  logic             gcd_done,
   input  logic [WIDTH-1:0] gcd_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_error,
   output logic             busy
);

   // Reject configurations that cannot work at elaboration time, so they
   // never reach silicon.
   if (WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("gcd_host_seq: WIDTH and TIMEOUT_CYCLES must both be >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t state;

   logic req_fire;
   logic a_zero;
   logic b_zero;

   assign req_fire = req_valid & req_ready;
   assign a_zero   = (req_a == '0);
   assign b_zero   = (req_b == '0);

`ifdef GCD_TIMEOUT_EN
   // One extra bit keeps the width nonzero when TIMEOUT_CYCLES is 1.
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;

   // wait_cnt holds the number of WAIT cycles already completed. The current
   // cycle is therefore the last one allowed when the count reaches
   // TIMEOUT_CYCLES-1.
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // All outputs are registered and driven from this single process.
   // req_ready and busy are state flags, kept as registers so that they are
   // glitch-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments only, so
         // every register samples the values that were present before the
         // edge, regardless of statement order.
         state      <= ST_IDLE;
         gcd_a      <= '0;
         gcd_b      <= '0;
         gcd_start  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_error  <= 1'b0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
`ifdef GCD_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         // gcd_start is high only in the cycle after an engine-path accept,
         // so it is cleared every cycle unless it is set again below.
         gcd_start <= 1'b0;

         case (state)
            ST_IDLE: begin
               // gcd_done arriving while idle is ignored.
               if (req_fire) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (!a_zero && !b_zero) begin
                     // The operands change only here and stay stable until
                     // the next accepted request.
                     gcd_a     <= req_a;
                     gcd_b     <= req_b;
                     gcd_start <= 1'b1;
                     state     <= ST_START;
                  end else begin
                     // Bypass path, the engine is not started.
                     // gcd(0, x) = x; if both operands are zero this
                     // selects zero, and the pair is flagged as an error.
                     rsp_result <= a_zero ? req_b : req_a;
                     rsp_error  <= a_zero & b_zero;
                     rsp_valid  <= 1'b1;
                     state      <= ST_RESP;
                  end
               end
            end

            ST_START: begin
               // gcd_start is high during this cycle. A gcd_done pulse seen
               // here is stale and is ignored.
               state <= ST_WAIT;
`ifdef GCD_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end

            ST_WAIT: begin
               // gcd_done is tested first, so a result arriving in the same
               // cycle as expiry is still returned as a normal result.
               if (gcd_done) begin
                  rsp_result <= gcd_result;
                  rsp_error  <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESP;
               end
`ifdef GCD_TIMEOUT_EN
               else if (timeout_hit) begin
                  rsp_result <= '0;
                  rsp_error  <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end

            ST_RESP: begin
               // rsp_result and rsp_error stay as captured. A gcd_done pulse
               // here (for example a late one after a timeout) is ignored.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_host_seq.sv
// -----------------------------------------------------------------------------
// tb_gcd_host_seq
//
// Self-checking bench for gcd_host_seq.
//
// The bench plays both the request source and the gcd engine. Expected
// responses come from a plain Euclid reference. The bench also keeps its own
// record of which operands the engine should currently see.
//
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, half a cycle after the DUT updates them.
// -----------------------------------------------------------------------------
module tb_gcd_host_seq;

   localparam int W = 32;
`ifdef GCD_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 4096;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic [W-1:0] gcd_a;
   logic [W-1:0] gcd_b;
   logic         gcd_start;
   logic         gcd_done;
   logic [W-1:0] gcd_result;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_error;
   logic         busy;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;

   // Operands the engine should currently be seeing.
   logic [W-1:0] exp_ga = '0;
   logic [W-1:0] exp_gb = '0;

   gcd_host_seq #(
      .WIDTH         (W),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .gcd_a     (gcd_a),
      .gcd_b     (gcd_b),
      .gcd_start (gcd_start),
      .gcd_done  (gcd_done),
      .gcd_result(gcd_result),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_result(rsp_result),
      .rsp_error (rsp_error),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Count start pulses. gcd_start is high for a whole cycle, so it is seen
   // at exactly one falling edge per pulse.
   always @(negedge clk) begin
      if (gcd_start === 1'b1) start_cnt++;
   end

   // Euclid's algorithm. gcd(0, x) = x and gcd(0, 0) = 0.
   function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // One complete job from request through response handshake.
   //   lat        : WAIT cycles before the engine answers (>= 1)
   //   hold       : cycles rsp_ready stays low once rsp_valid is up
   //   spur_start : also pulse a bogus gcd_done while the FSM is in START
   task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input int hold, input bit spur_start);
      logic [W-1:0] exp_res;
      logic         exp_err;
      bit           eng;
      int           s0;

      eng     = (a != 0) && (b != 0);
      exp_res = ref_gcd(a, b);
      exp_err = (a == 0) && (b == 0);
      s0      = start_cnt;

      total++;
      if ({req_ready, busy} !== 2'b10) begin
         bad++;
         $display("FAIL job_idle (%0d,%0d): req_ready/busy=%b%b required 10", a, b, req_ready, busy);
      end

      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      @(negedge clk);
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
      if (eng) begin
         exp_ga = a;
         exp_gb = b;
      end

      // Cycle N+1: engine path shows the start pulse; bypass path shows the
      // response already.
      total++;
      if ({gcd_start, rsp_valid, req_ready, busy, gcd_a, gcd_b} !==
          {eng, !eng, 1'b0, 1'b1, exp_ga, exp_gb}) begin
         bad++;
         $display("FAIL job_n1 (%0d,%0d): start=%b rv=%b rr=%b busy=%b ga=%0d gb=%0d required start=%b rv=%b rr=0 busy=1 ga=%0d gb=%0d",
                  a, b, gcd_start, rsp_valid, req_ready, busy, gcd_a, gcd_b, eng, !eng, exp_ga, exp_gb);
      end

      if (eng) begin
         if (spur_start) begin
            gcd_done   = 1'b1;
            gcd_result = ~exp_res;
         end
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            gcd_done = 1'b0;
            total++;
            if ({gcd_start, rsp_valid, busy, gcd_a, gcd_b} !== {2'b00, 1'b1, exp_ga, exp_gb}) begin
               bad++;
               $display("FAIL job_wait (%0d,%0d) cyc %0d: start=%b rv=%b busy=%b ga=%0d gb=%0d required 0/0/1 ga=%0d gb=%0d",
                        a, b, i, gcd_start, rsp_valid, busy, gcd_a, gcd_b, exp_ga, exp_gb);
            end
         end
         gcd_done   = 1'b1;
         gcd_result = exp_res;
         @(negedge clk);
         gcd_done   = 1'b0;
         gcd_result = $urandom;
      end

      rsp_ready = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) @(negedge clk);
         total++;
         if ({rsp_valid, rsp_result, rsp_error, req_ready, gcd_start, gcd_a, gcd_b} !==
             {1'b1, exp_res, exp_err, 2'b00, exp_ga, exp_gb}) begin
            bad++;
            $display("FAIL job_rsp (%0d,%0d) cyc %0d: rv=%b res=%0d err=%b rr=%b start=%b required rv=1 res=%0d err=%b rr=0 start=0",
                     a, b, i, rsp_valid, rsp_result, rsp_error, req_ready, gcd_start, exp_res, exp_err);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      total++;
      if ({rsp_valid, req_ready, busy} !== 3'b010 || (start_cnt - s0) != int'(eng)) begin
         bad++;
         $display("FAIL job_end (%0d,%0d): rv=%b rr=%b busy=%b starts=%0d required 0/1/0 starts=%0d",
                  a, b, rsp_valid, req_ready, busy, start_cnt - s0, int'(eng));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({gcd_a, gcd_b, gcd_start, rsp_valid, rsp_result, rsp_error, busy} !== '0) begin
         bad++;
         $display("FAIL reset_vals: ga=%0d gb=%0d start=%b rv=%b res=%0d err=%b busy=%b required all 0",
                  gcd_a, gcd_b, gcd_start, rsp_valid, rsp_result, rsp_error, busy);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if ({req_ready, busy} !== 2'b10) begin
         bad++;
         $display("FAIL reset_release: req_ready/busy=%b%b required 10", req_ready, busy);
      end
      exp_ga = '0;
      exp_gb = '0;
   endtask

   task automatic test_engine_basic();
      run_job(32'd48, 32'd18, 5, 0, 1'b0);
   endtask

   task automatic test_bypass();
      run_job(32'd0, 32'd35, 1, 0, 1'b0);
      run_job(32'd35, 32'd0, 1, 1, 1'b0);
      run_job(32'd0, 32'd0, 1, 0, 1'b0);
   endtask

   task automatic test_rsp_backpressure();
      run_job(32'd21, 32'd14, 3, 10, 1'b0);
   endtask

   task automatic test_reset_mid_job();
      req_valid = 1'b1;
      req_a     = 32'd100;
      req_b     = 32'd75;
      @(negedge clk);
      req_valid = 1'b0;
      total++;
      if (gcd_start !== 1'b1) begin
         bad++;
         $display("FAIL midrst_start: gcd_start=%b required 1", gcd_start);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({gcd_a, gcd_b, gcd_start, rsp_valid, rsp_result, rsp_error, busy} !== '0) begin
         bad++;
         $display("FAIL midrst_clear: ga=%0d gb=%0d start=%b rv=%b res=%0d err=%b busy=%b required all 0",
                  gcd_a, gcd_b, gcd_start, rsp_valid, rsp_result, rsp_error, busy);
      end
      reset  = 1'b0;
      exp_ga = '0;
      exp_gb = '0;
      @(negedge clk);
      total++;
      if ({req_ready, busy} !== 2'b10) begin
         bad++;
         $display("FAIL midrst_release: req_ready/busy=%b%b required 10", req_ready, busy);
      end
      // A late done from the aborted job must not produce a response.
      gcd_done   = 1'b1;
      gcd_result = 32'd25;
      @(negedge clk);
      gcd_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({rsp_valid, busy, req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL midrst_late_done cyc %0d: rv=%b busy=%b rr=%b required 0/0/1", i, rsp_valid, busy, req_ready);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_spurious_done();
      gcd_done   = 1'b1;
      gcd_result = 32'd77;
      @(negedge clk);
      gcd_done = 1'b0;
      total++;
      if ({rsp_valid, busy, req_ready} !== 3'b001) begin
         bad++;
         $display("FAIL spur_idle: rv=%b busy=%b rr=%b required 0/0/1", rsp_valid, busy, req_ready);
      end
      run_job(32'd27, 32'd18, 3, 1, 1'b1);
      run_job(32'd9, 32'd6, 2, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      for (int n = 0; n < 24; n++) begin
         a = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
         b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
         if (n % 3 == 0 && a != 0) a = a * W'($urandom_range(1, 30));
         run_job(a, b, $urandom_range(1, 6), $urandom_range(0, 3), bit'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_timeout();
      req_valid = 1'b1;
      req_a     = 32'd12;
      req_b     = 32'd8;
      @(negedge clk);
      req_valid = 1'b0;
      exp_ga    = 32'd12;
      exp_gb    = 32'd8;
      total++;
      if (gcd_start !== 1'b1) begin
         bad++;
         $display("FAIL to_start: gcd_start=%b required 1", gcd_start);
      end
`ifdef GCD_TIMEOUT_EN
      repeat (TO) @(negedge clk);
      total++;
      if ({rsp_valid, busy} !== 2'b01) begin
         bad++;
         $display("FAIL to_early: rv=%b busy=%b required 0/1 after %0d WAIT-side edges", rsp_valid, busy, TO);
      end
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_result, rsp_error, gcd_a, gcd_b} !== {1'b1, 32'd0, 1'b1, exp_ga, exp_gb}) begin
         bad++;
         $display("FAIL to_expire: rv=%b res=%0d err=%b required rv=1 res=0 err=1", rsp_valid, rsp_result, rsp_error);
      end
      // A late done after the abort is ignored.
      gcd_done   = 1'b1;
      gcd_result = 32'd4;
      @(negedge clk);
      gcd_done  = 1'b0;
      rsp_ready = 1'b1;
      total++;
      if ({rsp_valid, rsp_result, rsp_error} !== {1'b1, 32'd0, 1'b1}) begin
         bad++;
         $display("FAIL to_late_done: rv=%b res=%0d err=%b required rv=1 res=0 err=1", rsp_valid, rsp_result, rsp_error);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      total++;
      if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         bad++;
         $display("FAIL to_end: rv=%b rr=%b busy=%b required 0/1/0", rsp_valid, req_ready, busy);
      end
`else
      repeat (1000) @(negedge clk);
      total++;
      if ({rsp_valid, busy, req_ready} !== 3'b010) begin
         bad++;
         $display("FAIL no_timeout_hold: rv=%b busy=%b rr=%b required 0/1/0 after 1000 cycles", rsp_valid, busy, req_ready);
      end
      // Clear the hung job so later tests start from IDLE.
      reset = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      exp_ga = '0;
      exp_gb = '0;
      @(negedge clk);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_a      = '0;
      req_b      = '0;
      gcd_done   = 1'b0;
      gcd_result = '0;
      rsp_ready  = 1'b0;

      test_reset();
      test_engine_basic();
      test_bypass();
      test_rsp_backpressure();
      test_reset_mid_job();
      test_spurious_done();
      test_timeout();
      test_random();
      // Back-to-back jobs with immediate response consumption.
      run_job(32'd1071, 32'd462, 1, 0, 1'b0);
      run_job(32'd0, 32'd7, 1, 0, 1'b0);
      run_job(32'd17, 32'd5, 1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
